// File: rtl/pong_score_keeper.sv
// -----------------------------------------------------------------------------
// pong_score_keeper
//
// Two-player Pong score counter. Point strobes from the ball/collision logic
// are synchronised and edge-detected, then counted into per-player BCD
// scores (tens/ones, saturating at 99). The block detects the end of the game
// and drives the digit buses for the seven-segment decoders.
//
// Parameters:
//   WIN_SCORE  points needed to win (legal range 1..99)
//
// Ports:
//   CLK                 system clock, rising edge
//   RESETN              asynchronous active-low reset
//   P1_POINT, P2_POINT  point strobes (may be asynchronous), one point per rise
//   NEW_GAME            synchronous clear to 0-0, restart play
//   P1_TENS, P1_ONES    player 1 score, BCD
//   P2_TENS, P2_ONES    player 2 score, BCD
//   GAME_OVER           high once a player has won
//   WINNER              00 none, 01 player 1, 10 player 2
//
// Build option:
//   PONG_WIN_BY_TWO_EN  when defined, a win also needs a lead of at least two
//                       (a point scored at 99 wins outright).
// -----------------------------------------------------------------------------
module pong_score_keeper #(
  parameter int unsigned WIN_SCORE = 11
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       P1_POINT,
  input  logic       P2_POINT,
  input  logic       NEW_GAME,
  output logic [3:0] P1_TENS,
  output logic [3:0] P1_ONES,
  output logic [3:0] P2_TENS,
  output logic [3:0] P2_ONES,
  output logic       GAME_OVER,
  output logic [1:0] WINNER
);

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_e;

  localparam logic [6:0] WIN_BIN = 7'(WIN_SCORE);

  state_e     state_q, state_d;
  logic [7:0] p1_q, p1_d;       // {tens, ones}
  logic [7:0] p2_q, p2_d;
  logic [1:0] winner_q, winner_d;

  // Bit 0 carries player 1, bit 1 player 2.
  logic [1:0] s1_q, s2_q, prv_q;
  logic [1:0] ev;

  logic [7:0] p1_nxt, p2_nxt;
  logic       p1_win, p2_win;

  // BCD increment with saturation at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [6:0] bcd2bin(input logic [7:0] v);
    return (7'(v[7:4]) * 7'd10) + 7'(v[3:0]);
  endfunction

  assign ev     = s2_q & ~prv_q;
  assign p1_nxt = bcd_inc(p1_q);
  assign p2_nxt = bcd_inc(p2_q);

`ifdef PONG_WIN_BY_TWO_EN
  // The lead test uses the opponent's current score; it cannot change in the
  // same cycle because simultaneous events are discarded.
  assign p1_win = (p1_q == 8'h99) ||
                  ((bcd2bin(p1_nxt) >= WIN_BIN) &&
                   (bcd2bin(p1_nxt) >= bcd2bin(p2_q) + 7'd2));
  assign p2_win = (p2_q == 8'h99) ||
                  ((bcd2bin(p2_nxt) >= WIN_BIN) &&
                   (bcd2bin(p2_nxt) >= bcd2bin(p1_q) + 7'd2));
`else
  assign p1_win = (bcd2bin(p1_nxt) == WIN_BIN);
  assign p2_win = (bcd2bin(p2_nxt) == WIN_BIN);
`endif

  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    winner_d = winner_q;
    if (NEW_GAME) begin
      state_d  = PLAY;
      p1_d     = '0;
      p2_d     = '0;
      winner_d = '0;
    end else if (state_q == PLAY) begin
      unique case (ev)
        2'b01: begin
          p1_d = p1_nxt;
          if (p1_win) begin
            state_d  = OVER;
            winner_d = 2'b01;
          end
        end
        2'b10: begin
          p2_d = p2_nxt;
          if (p2_win) begin
            state_d  = OVER;
            winner_d = 2'b10;
          end
        end
        default: ;  // no event, or simultaneous events discarded
      endcase
    end
  end

  // Synchroniser/edge registers run regardless of NEW_GAME so a held input
  // does not re-score after the clear.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      s1_q     <= '0;
      s2_q     <= '0;
      prv_q    <= '0;
      state_q  <= PLAY;
      p1_q     <= '0;
      p2_q     <= '0;
      winner_q <= '0;
    end else begin
      s1_q     <= {P2_POINT, P1_POINT};
      s2_q     <= s1_q;
      prv_q    <= s2_q;
      state_q  <= state_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      winner_q <= winner_d;
    end
  end

  assign P1_TENS   = p1_q[7:4];
  assign P1_ONES   = p1_q[3:0];
  assign P2_TENS   = p2_q[7:4];
  assign P2_ONES   = p2_q[3:0];
  assign GAME_OVER = (state_q == OVER);
  assign WINNER    = winner_q;

endmodule
